// File: rtl/pcihellocore_pio_pkg.sv
// Purpose : shared constants and helpers for the pcihellocore PIO slaves (button input port, hex output port).
// Latency : n/a (package only).
// Backpressure: n/a. Contents: s1 register addresses, edge-type selectors, edge qualification helper.
package pcihellocore_pio_pkg;

    // s1 register map (2-bit word address)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge capture selectors
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Decides whether a filtered transition to new_val counts as a capturable edge.
    function automatic logic edge_qualifies(input int edge_type, input logic new_val);
        logic hit;
        case (edge_type)
            EDGE_RISE: hit = new_val;
            EDGE_FALL: hit = !new_val;
            EDGE_ANY:  hit = 1'b1;
            default:   hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// Purpose : one input bit: 2-flop synchronizer followed by a stable-count debounce filter.
// Latency : filt follows a sync1 sample DEBOUNCE_CYCLES+1 edges later if the input holds still.
// Backpressure: none. Ports: clk, reset_n, din (async raw), filt (debounced), upd (1-cycle strobe, filt changes
//           on the coming edge), new_val (value filt takes when upd is high).
module pcihellocore_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt,
    output logic upd,
    output logic new_val
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    assign new_val = sync2;
    // Combinational so the owner can capture the edge on the same clock filt changes.
    assign upd     = (sync2 != filt) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == filt) begin
                // Any return to the filtered level (a glitch) restarts the count.
                cnt <= '0;
            end else if (upd) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pcihellocore_button_inport.sv
// Purpose : Avalon-MM s1 input PIO: debounced inputs, edge capture (W1C), interrupt mask, level irq.
// Latency : readdata is combinational (0 wait states); writes land on the sampling edge.
// Backpressure: none, slave always accepts. Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata
//           (s1 bus), in_port (raw async inputs), irq (level, active high).
module pcihellocore_button_inport
    import pcihellocore_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_clr;
    logic             bus_wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .filt   (filt[i]),
            .upd    (upd[i]),
            .new_val(new_val[i])
        );
        assign edge_hit[i] = upd[i] && edge_qualifies(EDGE_TYPE, new_val[i]);
    end

    assign bus_wr       = chipselect && !write_n;
    assign edgecap_clr  = (bus_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    // Bits of writedata above WIDTH have no register behind them.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (bus_wr && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // Clear first, then set: a fresh edge survives a simultaneous W1C.
            edgecap <= (edgecap & ~edgecap_clr) | edge_hit;
        end
    end

    // Registers only, so there is no combinational path from the bus to irq.
    assign irq = |(edgecap & irqmask);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = filt;
            ADDR_DIR:     readdata = '0;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pcihellocore_button_inport.sv
// Purpose : self-checking bench for pcihellocore_button_inport; any-edge and falling-edge builds share stimulus.
// Latency : n/a.
// Backpressure: n/a.
module tb_pcihellocore_button_inport;

    localparam int W  = 8;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_any;
    logic [31:0]   rd_fall;
    logic          irq_any;
    logic          irq_fall;

    always #5 clk = ~clk;

    pcihellocore_button_inport #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    pcihellocore_button_inport #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: a filtered bit flips to v at an edge when the raw samples taken
    // 2..DC+1 edges earlier all equal v and v differs from the current filtered value.
    logic [W-1:0] m_filt;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_ecap_any;
    logic [W-1:0] m_ecap_fall;
    logic [W-1:0] m_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a, input logic [W-1:0] ecap);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0:    v = 32'(m_filt);
            2'd2:    v = 32'(m_mask);
            2'd3:    v = 32'(ecap);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_filt      = '0;
        m_mask      = '0;
        m_ecap_any  = '0;
        m_ecap_fall = '0;
        m_hist.delete();
        for (int j = 0; j < DC + 1; j++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] flip;
        logic [W-1:0] clr;
        logic [W-1:0] nf;
        flip = '0;
        for (int i = 0; i < W; i++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= DC; j++)
                if (m_hist[m_hist.size() - 1 - j][i] == m_filt[i]) all_diff = 1'b0;
            flip[i] = all_diff;
        end
        nf  = m_filt ^ flip;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_ecap_any  = (m_ecap_any & ~clr) | flip;
        m_ecap_fall = (m_ecap_fall & ~clr) | (flip & ~nf);
        m_filt      = nf;
        m_hist.push_back(in_port);
        void'(m_hist.pop_front());
    endtask

    task automatic check_model();
        chk("model_rd_any",   rd_any,          m_read(address, m_ecap_any));
        chk("model_irq_any",  32'(irq_any),    32'(|(m_ecap_any & m_mask)));
        chk("model_rd_fall",  rd_fall,         m_read(address, m_ecap_fall));
        chk("model_irq_fall", 32'(irq_fall),   32'(|(m_ecap_fall & m_mask)));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        else model_reset();
        @(negedge clk);
        check_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, rd_any, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = 8'hFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        model_reset();
        steps(3);
        chk("reset_data", rd_any, 32'h0);
        chk("reset_irq",  32'(irq_any), 32'h0);

        // Reset release with all inputs high: rising edges appear once debounced.
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("release_hold", rd_any, 32'h0);
        end
        step();
        chk("release_data", rd_any, 32'hFF);
        rd(2'd3, "release_ecap", 32'hFF);
        chk("release_ecap_fall", rd_fall, 32'h0);
        chk("release_irq", 32'(irq_any), 32'h0);
        wr(2'd3, 32'hFF);
        rd(2'd3, "ecap_cleared", 32'h0);

        // Debounce latency and glitch rejection
        in_port = 8'h00;
        steps(8);
        wr(2'd3, 32'hFF);
        address = 2'd0;
        in_port[0] = 1'b1;
        steps(5);
        chk("lat_before", 32'(rd_any[0]), 32'h0);
        step();
        chk("lat_exact", 32'(rd_any[0]), 32'h1);
        in_port[1] = 1'b1;
        steps(3);
        in_port[1] = 1'b0;
        steps(8);
        rd(2'd0, "glitch_data", 32'h01);
        rd(2'd3, "glitch_ecap", 32'h01);
        wr(2'd3, 32'hFF);

        // Interrupt path
        wr(2'd2, 32'h4);
        in_port[2] = 1'b1;
        steps(5);
        chk("irq_early", 32'(irq_any), 32'h0);
        step();
        chk("irq_set", 32'(irq_any), 32'h1);
        chk("irq_fall_build", 32'(irq_fall), 32'h0);
        wr(2'd3, 32'h4);
        chk("irq_w1c", 32'(irq_any), 32'h0);
        in_port[3] = 1'b1;
        steps(8);
        chk("irq_unmasked", 32'(irq_any), 32'h0);
        rd(2'd3, "ecap_bit3", 32'h08);
        wr(2'd3, 32'hFF);

        // W1C on the same edge as a fresh bit-0 capture
        in_port[0] = 1'b0;
        steps(5);
        rd(2'd3, "coll_pre", 32'h0);
        wr(2'd3, 32'h1);
        chk("coll_any", rd_any, 32'h1);
        chk("coll_fall", rd_fall, 32'h1);
        wr(2'd3, 32'hFF);

        // Falling-edge build ignores the rise, captures the fall
        in_port[5] = 1'b1;
        steps(8);
        address = 2'd3;
        #1;
        chk("fall_after_rise", rd_fall, 32'h0);
        in_port[5] = 1'b0;
        steps(8);
        chk("fall_after_fall", rd_fall, 32'h20);
        wr(2'd3, 32'hFF);

        // Bus map
        wr(2'd0, 32'hDEADBEEF);
        wr(2'd1, 32'hDEADBEEF);
        rd(2'd0, "map_data", 32'h0C);
        rd(2'd1, "map_dir", 32'h0);
        rd(2'd2, "map_mask_keep", 32'h4);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, "map_mask_wide", 32'h0000_00FF);
        wr(2'd2, 32'h0);

        // Randomized traffic against the model, with an asynchronous reset mid-run
        for (int it = 0; it < 1500; it++) begin
            int unsigned op;
            for (int b = 0; b < W; b++)
                if ($urandom_range(5) == 0) in_port[b] = ~in_port[b];
            if (it == 700) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                chk("arst_rd_any", rd_any, m_read(address, m_ecap_any));
                chk("arst_rd_fall", rd_fall, m_read(address, m_ecap_fall));
                chk("arst_irq", 32'(irq_any | irq_fall), 32'h0);
                steps(2);
                reset_n = 1'b1;
            end
            op = $urandom_range(7);
            if (op == 0) wr(2'd2, $urandom);
            else if (op == 1) wr(2'd3, $urandom);
            else begin
                address = 2'($urandom_range(3));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
